// File: rtl/mem_pkg.sv
// Shared MEM-stage types: sequencer states, RV32I load/store funct3 codes, alignment and lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size; bit 2 only selects zero-extension on loads.
    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts a byte/half/word from a read word and sign- or zero-extends it to 32 bits.
// Purely combinational; shared with the forwarding path.
module load_extend
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: captures a load/store, runs a req/ready handshake and extends load data.
// Latency 3 cycles in M (IDLE, REQ, DONE) plus one per extra low mem_ready cycle; StallM/FlushW hold the pipeline until DONE.
module dmem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FlushW,
    output logic        misalign_err,
    output logic        timeout_err
);

    state_t            state_q;
    state_t            state_d;
    logic [29:0]       addr_q;
    logic [1:0]        off_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;

    logic              acc;
    logic              aligned;
    logic              last_cycle;
    logic [31:0]       ext_data;

    assign acc        = MemReadM | MemWriteM;
    assign aligned    = is_aligned(Funct3M, ALUResultM[1:0]);
    assign last_cycle = (cnt_q == CNT_W'(TIMEOUT - 1));

    load_extend u_load_extend (
        .funct3 (f3_q),
        .offset (off_q),
        .word   (mem_rdata),
        .result (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        StallM       = 1'b0;
        FlushW       = 1'b0;
        misalign_err = 1'b0;
        timeout_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (aligned) begin
                        StallM  = 1'b1;
                        FlushW  = 1'b1;
                        state_d = REQ;
                    end else begin
                        misalign_err = 1'b1;
                    end
                end
            end
            REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                StallM  = 1'b1;
                FlushW  = 1'b1;
                if (mem_ready) begin
                    state_d = DONE;
                end else if (last_cycle) begin
                    timeout_err = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset wins over everything so an abandoned access never leaks a strobe or error.
        if (reset) begin
            state_d      = IDLE;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            StallM       = 1'b0;
            FlushW       = 1'b0;
            misalign_err = 1'b0;
            timeout_err  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (acc && aligned) begin
                        addr_q  <= ALUResultM[31:2];
                        off_q   <= ALUResultM[1:0];
                        be_q    <= byte_en(Funct3M, ALUResultM[1:0]);
                        wdata_q <= store_lanes(Funct3M, WriteDataM);
                        f3_q    <= Funct3M;
                        we_q    <= MemWriteM;
                        cnt_q   <= '0;
                    end else if (acc) begin
                        rdata_q <= '0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            rdata_q <= ext_data;
                        end
                    end else if (last_cycle) begin
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = {addr_q, 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    // A misaligned load advances the pipeline this very cycle, so it must see zero immediately.
    assign ReadDataM = misalign_err ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized accesses against a byte-level model.
module tb_dmem_access_ctrl;
    import mem_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [31:0] ReadDataM;
    logic        StallM, FlushW, misalign_err, timeout_err;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ReadDataM(ReadDataM), .StallM(StallM), .FlushW(FlushW),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model_rd = 32'd0;

    // Observations gathered by run_access for one instruction in M.
    int          o_stall, o_req, o_tmo, o_mis;
    logic        o_req_any, o_stable, o_done_seen, o_flush_done, o_stall_done, o_we;
    logic [31:0] o_addr, o_wdata, o_rd_idle, o_rd_done;
    logic [3:0]  o_be;

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_aligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int nb = nbytes(f3);
        int o  = int'(addr % 4);
        logic [3:0] be = 4'd0;
        for (int i = 0; i < 4; i++) if (i >= o && i < o + nb) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int nb = nbytes(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        int nb = nbytes(f3);
        longint v;
        v = longint'(word);
        v = v >> (8 * int'(addr % 4));
        v = v & ((longint'(1) << (8 * nb)) - 1);
        if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // n = REQ cycle (1-based) in which mem_ready is raised; 0 means never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata, input int n);
        o_stall = 0; o_req = 0; o_tmo = 0; o_mis = 0;
        o_req_any = 1'b0; o_stable = 1'b1; o_done_seen = 1'b0;
        o_flush_done = 1'bx; o_stall_done = 1'bx;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        mem_rdata = rdata; mem_ready = 1'b0;
        #1;
        o_stall += int'(StallM); o_mis += int'(misalign_err); o_req_any |= mem_req; o_rd_idle = ReadDataM;
        if (!StallM) begin
            @(negedge clk);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            #1;
            o_stall += int'(StallM); o_mis += int'(misalign_err); o_req_any |= mem_req; o_rd_done = ReadDataM;
            return;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            mem_ready = (cyc == n);
            #1;
            if (!mem_req) begin
                o_done_seen = 1'b1; o_rd_done = ReadDataM; o_flush_done = FlushW;
                o_stall_done = StallM; o_tmo += int'(timeout_err);
                break;
            end
            o_req++; o_stall += int'(StallM); o_tmo += int'(timeout_err);
            if (!FlushW) o_stable = 1'b0;
            if (o_req == 1) begin
                o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
            end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o_addr, o_be, o_wdata, o_we}) begin
                o_stable = 1'b0;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b1; Funct3M = F3_H; ALUResultM = 32'h101;
        WriteDataM = 32'h55; mem_rdata = 32'h0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if ({mem_req, mem_we, StallM, FlushW, misalign_err, timeout_err} !== 6'b0) begin
            bad++; $display("FAIL reset_outs_misaligned: got %b want 000000", {mem_req, mem_we, StallM, FlushW, misalign_err, timeout_err}); end
        total++; if (ReadDataM !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
        Funct3M = F3_W; ALUResultM = 32'h100;
        #1;
        total++; if ({mem_req, mem_we, StallM, FlushW} !== 4'b0) begin
            bad++; $display("FAIL reset_outs_aligned: got %b want 0000", {mem_req, mem_we, StallM, FlushW}); end
        @(negedge clk);
        reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
        #1;
        total++; if ({mem_req, StallM, ReadDataM} !== 34'd0) begin
            bad++; $display("FAIL post_reset_idle: got req=%b stall=%b rd=%h want 0", mem_req, StallM, ReadDataM); end
        model_rd = 32'd0;
    endtask

    task automatic test_lw();
        run_access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        model_rd = 32'hDEADBEEF;
        total++; if (o_stall !== 2) begin bad++; $display("FAIL lw_stall_cycles: got %0d want 2", o_stall); end
        total++; if (o_addr !== 32'h100 || o_be !== 4'hF) begin
            bad++; $display("FAIL lw_addr_be: got %h/%h want 00000100/f", o_addr, o_be); end
        total++; if (!o_done_seen || o_rd_done !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_rdata: got %h done=%b want deadbeef", o_rd_done, o_done_seen); end
        total++; if (o_flush_done !== 1'b0 || o_stall_done !== 1'b0) begin
            bad++; $display("FAIL lw_done_release: got flush=%b stall=%b want 0/0", o_flush_done, o_stall_done); end
    endtask

    task automatic test_sb();
        run_access(1'b0, 1'b1, F3_B, 32'h103, 32'h000000A5, 32'h13572468, 3);
        total++; if (o_be !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_addr !== 32'h100) begin
            bad++; $display("FAIL sb_lanes: got be=%b wdata=%h addr=%h want 1000/a5a5a5a5/00000100", o_be, o_wdata, o_addr); end
        total++; if (o_we !== 1'b1 || !o_stable) begin
            bad++; $display("FAIL sb_we_stable: got we=%b stable=%b want 1/1", o_we, o_stable); end
        total++; if (o_stall !== 4) begin bad++; $display("FAIL sb_stall_cycles: got %0d want 4", o_stall); end
        total++; if (o_rd_done !== model_rd) begin
            bad++; $display("FAIL sb_rdata_kept: got %h want %h", o_rd_done, model_rd); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, F3_B, 32'h202, 32'h0, 32'h12F03456, 1);
        total++; if (o_rd_done !== 32'hFFFFFFF0) begin bad++; $display("FAIL lb_sext: got %h want fffffff0", o_rd_done); end
        run_access(1'b1, 1'b0, F3_BU, 32'h202, 32'h0, 32'h12F03456, 2);
        total++; if (o_rd_done !== 32'h000000F0 || o_stall !== 3) begin
            bad++; $display("FAIL lbu_zext: got %h stall=%0d want 000000f0 stall=3", o_rd_done, o_stall); end
        model_rd = 32'h000000F0;
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, F3_H, 32'h101, 32'h0, 32'hCAFEF00D, 1);
        total++; if (o_mis !== 1) begin bad++; $display("FAIL mis_pulse: got %0d want 1", o_mis); end
        total++; if (o_req_any !== 1'b0 || o_stall !== 0) begin
            bad++; $display("FAIL mis_no_req: got req=%b stall=%0d want 0/0", o_req_any, o_stall); end
        total++; if (o_rd_idle !== 32'd0 || o_rd_done !== 32'd0) begin
            bad++; $display("FAIL mis_rdata: got %h/%h want 0", o_rd_idle, o_rd_done); end
        model_rd = 32'd0;
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 32'h89ABCDEF, 0);
        total++; if (o_req !== TMO || o_tmo !== 1) begin
            bad++; $display("FAIL tmo_cycles: got req=%0d tmo=%0d want %0d/1", o_req, o_tmo, TMO); end
        total++; if (!o_done_seen || o_rd_done !== 32'd0 || o_stall_done !== 1'b0) begin
            bad++; $display("FAIL tmo_done: got done=%b rd=%h stall=%b want 1/0/0", o_done_seen, o_rd_done, o_stall_done); end
        model_rd = 32'd0;
    endtask

    task automatic test_reset_mid();
        run_access(1'b1, 1'b0, F3_W, 32'h8, 32'h0, 32'h11112222, 1);
        model_rd = 32'h11112222;
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = F3_W; ALUResultM = 32'h300; mem_ready = 1'b0;
        mem_rdata = 32'h76543210;
        @(negedge clk);
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req1: got %b want 1", mem_req); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if ({mem_req, StallM, timeout_err} !== 3'b0) begin
            bad++; $display("FAIL rst_mid_forced: got %b want 000", {mem_req, StallM, timeout_err}); end
        @(negedge clk);
        reset = 1'b0; MemReadM = 1'b0;
        #1;
        total++; if ({mem_req, StallM, timeout_err} !== 3'b0 || ReadDataM !== 32'd0) begin
            bad++; $display("FAIL rst_mid_idle: got %b rd=%h want 000 rd=0", {mem_req, StallM, timeout_err}, ReadDataM); end
        model_rd = 32'd0;
        run_access(1'b1, 1'b0, F3_W, 32'h304, 32'h0, 32'h0BADF00D, 2);
        total++; if (!o_done_seen || o_rd_done !== 32'h0BADF00D || o_stall !== 3 || o_tmo !== 0) begin
            bad++; $display("FAIL rst_mid_next_lw: got rd=%h stall=%0d tmo=%0d want 0badf00d/3/0", o_rd_done, o_stall, o_tmo); end
        model_rd = 32'h0BADF00D;
    endtask

    task automatic test_random();
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdw;
        logic        rd, wr, al, tmo;
        int          n, kind, exp_req;
        f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int it = 0; it < 40; it++) begin
            f3   = f3s[$urandom_range(0, 4)];
            addr = $urandom;
            wd   = $urandom;
            rdw  = $urandom;
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            n    = $urandom_range(0, TMO + 1);
            al   = m_aligned(f3, addr);
            run_access(rd, wr, f3, addr, wd, rdw, n);
            if (!al) begin
                model_rd = 32'd0;
                total++; if (o_mis !== 1 || o_req_any !== 1'b0 || o_rd_done !== 32'd0) begin
                    bad++; $display("FAIL rnd%0d_misalign: got mis=%0d req=%b rd=%h want 1/0/0", it, o_mis, o_req_any, o_rd_done); end
            end else begin
                tmo     = !(n >= 1 && n <= TMO);
                exp_req = tmo ? TMO : n;
                if (tmo) model_rd = 32'd0;
                else if (!wr) model_rd = m_load(f3, addr, rdw);
                total++; if (!o_done_seen || o_req !== exp_req || o_tmo !== int'(tmo) || o_stall !== exp_req + 1) begin
                    bad++; $display("FAIL rnd%0d_timing: got done=%b req=%0d tmo=%0d stall=%0d want req=%0d tmo=%0d",
                                    it, o_done_seen, o_req, o_tmo, o_stall, exp_req, tmo); end
                total++; if (o_addr !== (addr & 32'hFFFFFFFC) || o_be !== m_be(f3, addr) || o_we !== wr || !o_stable) begin
                    bad++; $display("FAIL rnd%0d_req: got addr=%h be=%b we=%b stable=%b want addr=%h be=%b we=%b",
                                    it, o_addr, o_be, o_we, o_stable, addr & 32'hFFFFFFFC, m_be(f3, addr), wr); end
                if (wr) begin
                    total++; if (o_wdata !== m_wdata(f3, wd)) begin
                        bad++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o_wdata, m_wdata(f3, wd)); end
                end
                total++; if (o_rd_done !== model_rd || o_flush_done !== 1'b0) begin
                    bad++; $display("FAIL rnd%0d_rdata: got %h flush=%b want %h flush=0", it, o_rd_done, o_flush_done, model_rd); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b0; ALUResultM = 32'd0;
        WriteDataM = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sb();
        test_back_to_back();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
